// File: rtl/wb_store_buffer.sv
// ============================================================================
// wb_store_buffer : in-order pending-store FIFO draining to the data-memory port
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_store_buffer #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_enable,
  input  logic [ADDRESS_WIDTH-1:0]     in_phy_addr,
  input  logic [DATA_WIDTH-1:0]        in_wdata,
  input  logic [3:0]                   in_size,
  output logic                         out_ready,
  output logic                         out_err,
  output logic                         out_mem_req,
  output logic [ADDRESS_WIDTH-1:0]     out_mem_addr,
  output logic [DATA_WIDTH-1:0]        out_mem_data,
  output logic [7:0]                   out_mem_strb,
  input  logic                         in_mem_ack,
  input  logic                         in_ld_valid,
  input  logic [ADDRESS_WIDTH-1:0]     in_ld_addr,
  output logic                         out_ld_hazard,
  output logic                         out_empty,
  output logic [$clog2(DEPTH):0]       out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic                      req_q, req_d;
  logic [ADDRESS_WIDTH-1:0]  maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0]     mdata_q, mdata_d;
  logic [7:0]                mstrb_q, mstrb_d;
  logic                      err_q;
  logic [CNT_W-1:0]          count_q;
  logic [PTR_W-1:0]          head_q, tail_q;
  logic [DEPTH-1:0]          valid_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]     data_q [DEPTH];
  logic [7:0]                strb_q [DEPTH];

  logic [2:0]                w_off;
  logic [7:0]                w_size_mask;
  logic                      w_size_ok;
  logic                      w_legal;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_err;
  logic [PTR_W-1:0]          w_head_nxt;
  logic [ADDRESS_WIDTH-1:0]  w_in_addr;
  logic [DATA_WIDTH-1:0]     w_in_data;
  logic [7:0]                w_in_strb;
  logic [7:0]                w_ld_mask;
  logic                      w_hit;

  assign w_off     = in_phy_addr[2:0];
  assign w_in_addr = {in_phy_addr[ADDRESS_WIDTH-1:3], 3'b000};
  assign w_in_data = in_wdata << {w_off, 3'b000};
  assign w_in_strb = w_size_mask << w_off;
  assign out_ready = (count_q < CNT_W'(DEPTH));

  always_comb begin
    w_size_mask = 8'h00;
    w_size_ok   = 1'b1;
    case (in_size)
      4'd1:    w_size_mask = 8'h01;
      4'd2:    w_size_mask = 8'h03;
      4'd4:    w_size_mask = 8'h0F;
      4'd8:    w_size_mask = 8'hFF;
      default: w_size_ok   = 1'b0;
    endcase
    // size-1 in three bits gives the alignment mask (8 wraps to 7)
    w_legal = w_size_ok && ((w_off & (in_size[2:0] - 3'd1)) == 3'd0);
  end

  assign w_push     = in_enable && out_ready && w_legal;
  assign w_err      = in_enable && out_ready && !w_legal;
  assign w_head_nxt = head_q + PTR_W'(1);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mstrb_d = mstrb_q;
    w_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = REQ;
          req_d   = 1'b1;
          maddr_d = addr_q[head_q];
          mdata_d = data_q[head_q];
          mstrb_d = strb_q[head_q];
        end else if (w_push) begin
          state_d = REQ;
          req_d   = 1'b1;
          maddr_d = w_in_addr;
          mdata_d = w_in_data;
          mstrb_d = w_in_strb;
        end
      end
      REQ: begin
        if (in_mem_ack) begin
          w_pop = 1'b1;
          if (count_q > CNT_W'(1)) begin
            maddr_d = addr_q[w_head_nxt];
            mdata_d = data_q[w_head_nxt];
            mstrb_d = strb_q[w_head_nxt];
          end else if (w_push) begin
            // the only remaining store is the one being committed now
            maddr_d = w_in_addr;
            mdata_d = w_in_data;
            mstrb_d = w_in_strb;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      mstrb_q <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mstrb_q <= mstrb_d;
      err_q   <= w_err;
      if (w_push && !w_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (w_pop) begin
        head_q          <= w_head_nxt;
        valid_q[head_q] <= 1'b0;
      end
      if (w_push) begin
        tail_q          <= tail_q + PTR_W'(1);
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      addr_q[tail_q] <= w_in_addr;
      data_q[tail_q] <= w_in_data;
      strb_q[tail_q] <= w_in_strb;
    end
  end

  // Loads are treated as touching all eight lanes whatever their offset
  assign w_ld_mask = 8'hFF | {5'b00000, in_ld_addr[2:0]};

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] &&
          (addr_q[i][ADDRESS_WIDTH-1:3] == in_ld_addr[ADDRESS_WIDTH-1:3]) &&
          ((strb_q[i] & w_ld_mask) != 8'h00)) begin
        w_hit = 1'b1;
      end
    end
  end

  assign out_ld_hazard = in_ld_valid && w_hit;
  assign out_err       = err_q;
  assign out_mem_req   = req_q;
  assign out_mem_addr  = maddr_q;
  assign out_mem_data  = mdata_q;
  assign out_mem_strb  = mstrb_q;
  assign out_empty     = (count_q == '0) && (state_q == IDLE);
  assign out_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_store_buffer.sv
// ============================================================================
// tb_wb_store_buffer : directed + randomized bench with a queue reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_wb_store_buffer;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_enable;
  logic [AW-1:0] in_phy_addr;
  logic [DW-1:0] in_wdata;
  logic [3:0]    in_size;
  logic          out_ready;
  logic          out_err;
  logic          out_mem_req;
  logic [AW-1:0] out_mem_addr;
  logic [DW-1:0] out_mem_data;
  logic [7:0]    out_mem_strb;
  logic          in_mem_ack;
  logic          in_ld_valid;
  logic [AW-1:0] in_ld_addr;
  logic          out_ld_hazard;
  logic          out_empty;
  logic [2:0]    out_count;

  wb_store_buffer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .in_phy_addr(in_phy_addr),
    .in_wdata(in_wdata), .in_size(in_size), .out_ready(out_ready), .out_err(out_err),
    .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
    .out_mem_strb(out_mem_strb), .in_mem_ack(in_mem_ack), .in_ld_valid(in_ld_valid),
    .in_ld_addr(in_ld_addr), .out_ld_hazard(out_ld_hazard), .out_empty(out_empty),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  s;
  } ent_t;

  ent_t q[$];
  logic exp_err;
  int   checks   = 0;
  int   failures = 0;

  function automatic bit legal(input logic [63:0] a, input logic [3:0] sz);
    if (!(sz == 4'd1 || sz == 4'd2 || sz == 4'd4 || sz == 4'd8)) return 1'b0;
    return (a % 64'(sz)) == 64'd0;
  endfunction

  function automatic ent_t mk(input logic [63:0] a, input logic [63:0] d, input logic [3:0] sz);
    ent_t e;
    int   off;
    logic [15:0] m;
    off = int'(a % 64'd8);
    m   = ((16'd1 << sz) - 16'd1) << off;
    e.a = a - 64'(off);
    e.d = d << (8 * off);
    e.s = m[7:0];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard(input logic [63:0] la);
    foreach (q[i]) if ((q[i].a >> 3) == (la >> 3)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input bit en, input logic [63:0] a, input logic [63:0] d,
                     input logic [3:0] sz, input bit ack, input bit ldv,
                     input logic [63:0] la);
    bit   push, pop, errn;
    ent_t e;
    in_enable = en; in_phy_addr = a; in_wdata = d; in_size = sz;
    in_mem_ack = ack; in_ld_valid = ldv; in_ld_addr = la;
    #1;
    chk("count", 64'(out_count), 64'(q.size()));
    chk("ready", 64'(out_ready), 64'(q.size() < DEPTH));
    chk("req",   64'(out_mem_req), 64'(q.size() != 0));
    chk("empty", 64'(out_empty), 64'(q.size() == 0));
    chk("err",   64'(out_err), 64'(exp_err));
    chk("hazard", 64'(out_ld_hazard), 64'(ldv && model_hazard(la)));
    if (q.size() != 0) begin
      chk("mem_addr", out_mem_addr, q[0].a);
      chk("mem_data", out_mem_data, q[0].d);
      chk("mem_strb", 64'(out_mem_strb), 64'(q[0].s));
    end
    pop  = ack && (q.size() != 0);
    push = en && (q.size() < DEPTH) && legal(a, sz);
    errn = en && (q.size() < DEPTH) && !legal(a, sz);
    e    = mk(a, d, sz);
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
    exp_err = errn;
    @(negedge clk);
  endtask

  task automatic idle(input bit ack);
    cyc(1'b0, 64'd0, 64'd0, 4'd8, ack, 1'b0, 64'd0);
  endtask

  task automatic rst_pulse();
    reset = 1'b1; in_enable = 1'b0; in_mem_ack = 1'b0; in_ld_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    exp_err = 1'b0;
  endtask

  initial begin
    logic [3:0]  szs [6];
    logic [3:0]  sz;
    logic [63:0] a;
    szs = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd8};
    exp_err = 1'b0;
    in_phy_addr = '0; in_wdata = '0; in_size = 4'd8; in_ld_addr = '0;
    rst_pulse();
    chk("rst_req",   64'(out_mem_req), 64'd0);
    chk("rst_addr",  out_mem_addr, 64'd0);
    chk("rst_data",  out_mem_data, 64'd0);
    chk("rst_strb",  64'(out_mem_strb), 64'd0);
    chk("rst_empty", 64'(out_empty), 64'd1);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_err",   64'(out_err), 64'd0);

    // doubleword store, ack after two cycles
    cyc(1'b1, 64'h1000, 64'h1122334455667788, 4'd8, 1'b0, 1'b0, 64'd0);
    chk("sd_req",  64'(out_mem_req), 64'd1);
    chk("sd_addr", out_mem_addr, 64'h1000);
    chk("sd_strb", 64'(out_mem_strb), 64'hFF);
    chk("sd_data", out_mem_data, 64'h1122334455667788);
    idle(1'b0);
    idle(1'b1);
    chk("sd_empty", 64'(out_empty), 64'd1);

    // byte store lane shift, then misaligned halfword
    cyc(1'b1, 64'h1005, 64'hAB, 4'd1, 1'b0, 1'b0, 64'd0);
    chk("sb_addr", out_mem_addr, 64'h1000);
    chk("sb_strb", 64'(out_mem_strb), 64'h20);
    chk("sb_data", out_mem_data, 64'h0000AB0000000000);
    idle(1'b1);
    cyc(1'b1, 64'h1003, 64'h1234, 4'd2, 1'b0, 1'b0, 64'd0);
    chk("sh_err",   64'(out_err), 64'd1);
    chk("sh_count", 64'(out_count), 64'd0);
    idle(1'b0);
    chk("sh_err_clr", 64'(out_err), 64'd0);

    // fill, drop a fifth, then drain back-to-back
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 64'h3000 + 64'(8 * i), {$urandom, $urandom}, 4'd8, 1'b0, 1'b0, 64'd0);
    chk("full_ready", 64'(out_ready), 64'd0);
    chk("full_count", 64'(out_count), 64'd4);
    cyc(1'b1, 64'h3100, 64'hDEAD, 4'd8, 1'b1, 1'b0, 64'd0);
    chk("full_drop", 64'(out_count), 64'd3);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("drain_empty", 64'(out_empty), 64'd1);

    // continuous push with continuous ack, wraps the pointers
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 64'h4000 + 64'(8 * i), {$urandom, $urandom}, 4'd8, 1'b1, 1'b0, 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("wrap_empty", 64'(out_empty), 64'd1);

    // load hazard probes
    cyc(1'b1, 64'h2004, 64'hDEADBEEF, 4'd4, 1'b0, 1'b0, 64'd0);
    in_ld_valid = 1'b1; in_ld_addr = 64'h2000; #1;
    chk("haz_hit", 64'(out_ld_hazard), 64'd1);
    in_ld_addr = 64'h2008; #1;
    chk("haz_miss", 64'(out_ld_hazard), 64'd0);
    cyc(1'b0, 64'd0, 64'd0, 4'd8, 1'b1, 1'b1, 64'h2000);
    in_ld_valid = 1'b1; in_ld_addr = 64'h2000; #1;
    chk("haz_after_ack", 64'(out_ld_hazard), 64'd0);

    // reset with a request outstanding, then a late ack
    cyc(1'b1, 64'h6000, 64'h11, 4'd8, 1'b0, 1'b0, 64'd0);
    cyc(1'b1, 64'h6008, 64'h22, 4'd8, 1'b0, 1'b0, 64'd0);
    chk("pre_rst_count", 64'(out_count), 64'd2);
    rst_pulse();
    chk("mid_rst_req",   64'(out_mem_req), 64'd0);
    chk("mid_rst_count", 64'(out_count), 64'd0);
    chk("mid_rst_empty", 64'(out_empty), 64'd1);
    idle(1'b1);
    idle(1'b0);

    // randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      sz = szs[$urandom_range(0, 5)];
      a  = 64'h5000 + 64'($urandom_range(0, 3) * 8) + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0 && sz != 4'd3) a = a & ~(64'(sz) - 64'd1);
      cyc($urandom_range(0, 2) != 0, a, {$urandom, $urandom}, sz,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          64'h5000 + 64'($urandom_range(0, 47)));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("final_empty", 64'(out_empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_store_buffer.md
Name: wb_store_buffer

Overview:
Receiving end of the writeback stage's pending-store path. Accepts store commits (sd/sw/sh/sb) from writeback, holds them in an in-order FIFO, and drains them to the data-memory port with a req/ack handshake. Also flags load hazards against buffered stores and reports when the buffer is fully drained, which syscall flush needs before an ecall.

Parameters:
ADDRESS_WIDTH, 64, physical address width
DATA_WIDTH, 64, store data / memory port width
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_enable  input  1  store commit valid from writeback
in_phy_addr  input  ADDRESS_WIDTH  store byte address
in_wdata  input  DATA_WIDTH  store data, LSB-aligned (rs2 value)
in_size  input  4  store size in bytes: 1, 2, 4 or 8
out_ready  output  1  buffer can accept a commit this cycle
out_err  output  1  one-cycle pulse: commit dropped (bad size or misaligned)
out_mem_req  output  1  memory write request valid
out_mem_addr  output  ADDRESS_WIDTH  doubleword-aligned address (low 3 bits zero)
out_mem_data  output  DATA_WIDTH  byte-lane-shifted write data
out_mem_strb  output  8  byte-lane write strobes
in_mem_ack  input  1  memory accepted the current request
in_ld_valid  input  1  load address probe valid
in_ld_addr  input  ADDRESS_WIDTH  load byte address
out_ld_hazard  output  1  probe overlaps a buffered store
out_empty  output  1  no entries and no request outstanding
out_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: all entries invalid, count=0, head=tail=0, FSM=IDLE, out_mem_req=0, out_mem_addr/data/strb=0, out_err=0, out_empty=1.
- out_ready = (count < DEPTH), combinational; it does not depend on in_mem_ack in the same cycle, so there is no full-buffer bypass.
- Push: occurs when in_enable && out_ready && the commit is legal. The entry stores addr[63:3]<<3, strb = ((1<<size)-1) << addr[2:0], and data = in_wdata << (8*addr[2:0]).
- Illegal commit: size not in {1,2,4,8}, or addr mod size != 0. No push; out_err=1 for the next cycle only.
- in_enable while full: the commit is dropped with no error. Writeback must honour out_ready.
- Drain FSM, outputs registered:
  - IDLE: if count>0, next cycle is REQ and the head entry loads onto the mem outputs with out_mem_req=1.
  - REQ: out_mem_req and addr/data/strb stay stable until in_mem_ack.
  - On ack: pop the head. If the remaining count >0, present the new head the next cycle (REQ, req stays 1). Otherwise go to IDLE with req=0 next cycle.
- Latency: a push at cycle N gives a request at cycle N+1 at the earliest. Back-to-back acks drain one entry per cycle.
- Simultaneous push and pop: count unchanged, pointers both advance. When count=DEPTH, push is refused even if ack arrives in the same cycle.
- Pointer wrap: head and tail are modulo DEPTH. count distinguishes full from empty.
- out_ld_hazard (combinational) = in_ld_valid && any valid entry (including the one currently presented) with addr[63:3]==in_ld_addr[63:3] and nonzero strobe overlap with the load's lane mask. The load mask is full 8 lanes (conservative). A commit arriving in the same cycle is not checked.
- out_empty = (count==0) && FSM==IDLE. The syscall path waits on out_empty before do_ecall.
- out_count reflects registered occupancy, with pushes and pops visible the cycle after.
- Reset mid-request: out_mem_req drops the cycle after reset is sampled, and entries are discarded. The memory side must ignore an ack arriving after reset.
- in_mem_ack while req=0 is ignored.

Test Plan:
- Reset, then sd addr=0x1000 data=0x1122334455667788 size=8 with ack after 2 cycles -> req at cycle+1, addr=0x1000, strb=0xFF, data unchanged. Req held 2 cycles, then empty=1.
- sb addr=0x1005 data=0xAB -> addr=0x1000, strb=0x20, data=0x0000AB0000000000. sh addr=0x1003 -> out_err pulse, count stays 0.
- Push 4 stores with ack held low -> out_ready=0 and count=4. A 5th in_enable is dropped. Raise ack every cycle -> four requests in program order on consecutive cycles, then IDLE.
- Push 6 stores with ack=1 continuously and a push each cycle -> exercises pointer wrap past DEPTH. All 6 drain in order with no loss or duplication.
- Buffer a sw at 0x2004, probe in_ld_addr=0x2000 -> hazard=1. Probe 0x2008 -> hazard=0. After the ack for the sw -> hazard=0.
- Two entries buffered with req=1, assert reset for 1 cycle -> next cycle req=0, count=0, empty=1. A late ack causes no pop and no underflow.
